// File: rtl/xs3_pkg.sv
// Shared types and constants for the BCD to Excess-3 sequencer.
// Holds the controller state encoding and the digit constants.
package xs3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CONV = 2'b01,
        DONE = 2'b10
    } xs3_state_e;

    localparam logic [3:0] XS3_BIAS = 4'd3;
    localparam logic [3:0] BCD_MAX  = 4'd9;

endpackage

// File: rtl/xs3_digit.sv
// Single-digit BCD to Excess-3 converter; flags digits above 9.
// Combinational, zero latency, no backpressure.
module xs3_digit
    import xs3_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out,
    output logic       invalid
);

    // Invalid digits still convert; the 4-bit add wraps (F -> 2).
    assign digit_out = digit_in + XS3_BIAS;
    assign invalid   = (digit_in > BCD_MAX);

endmodule

// File: rtl/xs3_seq_ctrl.sv
// Converts a packed NDIG-digit BCD word to Excess-3 one digit per cycle, LSB first.
// Result valid NDIG cycles after acceptance; held in DONE until out_ready, no input taken meanwhile.
module xs3_seq_ctrl
    import xs3_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*NDIG-1:0]   bcd_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*NDIG-1:0]   xs3_out,
    output logic                err,
    output logic                busy
);

    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NDIG - 1);

    xs3_state_e        state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [4*NDIG-1:0] bcd_q, bcd_d;
    logic [4*NDIG-1:0] xs3_q, xs3_d;
    logic              err_q, err_d;

    logic [3:0]        dig_bcd;
    logic [3:0]        dig_xs3;
    logic              dig_bad;

    always_comb begin
        dig_bcd = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_q == IDXW'(i)) begin
                dig_bcd = bcd_q[4*i +: 4];
            end
        end
    end

    xs3_digit u_digit (
        .digit_in  (dig_bcd),
        .digit_out (dig_xs3),
        .invalid   (dig_bad)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bcd_d   = bcd_q;
        xs3_d   = xs3_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bcd_d   = bcd_in;
                    xs3_d   = '0;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                for (int i = 0; i < NDIG; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        xs3_d[4*i +: 4] = dig_xs3;
                    end
                end
                err_d = err_q | dig_bad;
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            bcd_q   <= '0;
            xs3_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bcd_q   <= bcd_d;
            xs3_q   <= xs3_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == CONV) || (state_q == DONE);
    assign xs3_out   = xs3_q;
    assign err       = err_q;

endmodule

// File: tb/tb_xs3_seq_ctrl.sv
// Directed bench for xs3_seq_ctrl with NDIG=4: vector table plus backpressure,
// reset-in-flight and back-to-back sequences.
module tb_xs3_seq_ctrl;

    localparam int NDIG = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [4*NDIG-1:0]   bcd_in;
    logic                out_valid;
    logic                out_ready;
    logic [4*NDIG-1:0]   xs3_out;
    logic                err;
    logic                busy;

    int n_cmp = 0;
    int n_bad = 0;

    xs3_seq_ctrl #(.NDIG(NDIG)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xs3_out   (xs3_out),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        logic [15:0] exp_xs3;
        logic        exp_err;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offers one word, checks 4-cycle latency and the result, then drains it.
    task automatic run_word(input string name, input logic [15:0] w,
                            input logic [15:0] exp_x, input logic exp_e);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({name, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        bcd_in    = w;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        bcd_in   = 16'(~w);
        chk({name, " busy"}, 32'(busy), 32'd1);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({name, " latency"}, 32'(cyc), 32'd4);
        chk({name, " xs3"}, 32'(xs3_out), 32'(exp_x));
        chk({name, " err"}, 32'(err), 32'(exp_e));
        tick();
        chk({name, " idle"}, {30'd0, in_ready, out_valid}, 32'b10);
    endtask

    logic [15:0] b2b_in  [3];
    logic [15:0] b2b_exp [3];
    int          acc_cyc [3];

    initial begin
        vecs[0] = '{16'h9501, 16'hC834, 1'b0};
        vecs[1] = '{16'h0000, 16'h3333, 1'b0};
        vecs[2] = '{16'h9999, 16'hCCCC, 1'b0};
        vecs[3] = '{16'h1A23, 16'h4D56, 1'b1};
        vecs[4] = '{16'h0001, 16'h3334, 1'b0};
        vecs[5] = '{16'hFFFF, 16'h2222, 1'b1};
        vecs[6] = '{16'h0A0F, 16'h3D32, 1'b1};
        vecs[7] = '{16'h1234, 16'h4567, 1'b0};

        rst = 1'b1; in_valid = 1'b0; bcd_in = '0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset xs3", 32'(xs3_out), 32'd0);
        chk("reset err", 32'(err), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_word($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].exp_xs3, vecs[i].exp_err);
        end

        // Backpressure: held result, in_valid ignored in DONE and on the exit edge.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        bcd_in    = 16'h1A23;
        tick();
        bcd_in = 16'h7777;
        for (int c = 0; c < 20 && !out_valid; c++) tick();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d out_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d xs3", c), 32'(xs3_out), 32'h4D56);
            chk($sformatf("bp%0d err", c), 32'(err), 32'd1);
            chk($sformatf("bp%0d in_ready", c), 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp exit idle", {30'd0, in_ready, busy}, 32'b10);
        chk("bp exit out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        tick();
        chk("bp no capture", 32'(busy), 32'd0);

        // Reset mid-conversion at idx=2, with in_valid high during reset.
        in_valid = 1'b1;
        bcd_in   = 16'h8888;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("pre-rst busy", 32'(busy), 32'd1);
        rst      = 1'b1;
        in_valid = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst conv in_ready", 32'(in_ready), 32'd1);
        chk("rst conv out_valid", 32'(out_valid), 32'd0);
        chk("rst conv busy", 32'(busy), 32'd0);
        chk("rst conv xs3", 32'(xs3_out), 32'd0);
        tick();
        chk("rst no capture", 32'(busy), 32'd0);
        run_word("post-rst", 16'h2468, 16'h579B, 1'b0);

        // Back-to-back with in_valid held high.
        b2b_in[0] = 16'h0123; b2b_exp[0] = 16'h3456;
        b2b_in[1] = 16'h4567; b2b_exp[1] = 16'h789A;
        b2b_in[2] = 16'h8901; b2b_exp[2] = 16'hBC34;
        begin
            int k, r;
            k = 0; r = 0;
            out_ready = 1'b1;
            in_valid  = 1'b1;
            bcd_in    = b2b_in[0];
            for (int cyc = 0; cyc < 40; cyc++) begin
                if (out_valid && r < 3) begin
                    chk($sformatf("b2b%0d xs3", r), 32'(xs3_out), 32'(b2b_exp[r]));
                    r++;
                end
                if (in_ready && in_valid && k < 3) begin
                    acc_cyc[k] = cyc;
                    k++;
                end
                tick();
                if (k < 3) bcd_in = b2b_in[k];
                else in_valid = 1'b0;
            end
            chk("b2b accepted", 32'(k), 32'd3);
            chk("b2b results", 32'(r), 32'd3);
            if (k == 3) begin
                chk("b2b gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'(NDIG + 2));
                chk("b2b gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'(NDIG + 2));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/xs3_seq_ctrl.md
XS3_SEQ_CTRL -- requirements
Module: xs3_seq_ctrl

Interface
REQ-001 The block SHALL have parameter NDIG, default 4, giving the number of BCD digits per word (legal range 1..8).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset: synchronous, active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit, meaning the source offers bcd_in.
REQ-005 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts a word this cycle.
REQ-006 The block SHALL have port bcd_in, input, 4*NDIG bits, the packed BCD word; digit 0 is bits [3:0].
REQ-007 The block SHALL have port out_valid, output, 1 bit, meaning xs3_out and err are valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit, meaning the sink takes the result.
REQ-009 The block SHALL have port xs3_out, output, 4*NDIG bits, the packed Excess-3 result, with the same digit order as bcd_in.
REQ-010 The block SHALL have port err, output, 1 bit, meaning at least one input digit was greater than 9.
REQ-011 The block SHALL have port busy, output, 1 bit, which is high in CONV or DONE.

Function
REQ-012 The block SHALL sequence one shared single-digit converter across all NDIG digits, one digit per cycle, LSB digit first.
REQ-013 The block SHALL implement FSM states IDLE, CONV and DONE.
REQ-014 In IDLE, the block SHALL drive in_ready=1; when in_valid=1 it SHALL capture bcd_in, clear the result and error registers, set digit index to 0, and go to CONV.
REQ-015 In CONV, each cycle the block SHALL write digit[idx] = (bcd digit + 3) mod 16 into xs3_out bits [4*idx+3:4*idx], and OR (digit > 9) into err.
REQ-016 In CONV, the block SHALL increment idx, and go to DONE when idx == NDIG-1 on that cycle.
REQ-017 In DONE, the block SHALL hold out_valid=1 with xs3_out and err stable until out_ready=1, then go to IDLE the following edge.
REQ-018 The block SHALL produce latency as follows: acceptance edge T, out_valid first high after edge T+NDIG.
REQ-019 For an invalid digit (10..15), the block SHALL still write (digit+3) mod 16 (e.g. A->D, F->2) and set err.
REQ-020 The block SHALL drive in_ready=0 in CONV and DONE; in_valid SHALL be ignored there, with no acceptance in the DONE->IDLE cycle, so the minimum issue interval is NDIG+2 cycles.
REQ-021 While out_ready=0 in DONE, the block SHALL hold all outputs unchanged indefinitely, with no result loss.
REQ-022 The block SHALL not alter captured data if bcd_in changes after acceptance.
REQ-023 For NDIG=1, the block SHALL spend exactly one cycle in CONV.

Reset
REQ-024 On rst=1 at a clock edge, the block SHALL go to IDLE and clear idx, xs3_out, err and out_valid to 0; in_ready SHALL be 1 and busy 0 from the next cycle.
REQ-025 On reset in CONV or DONE, the block SHALL drop the in-flight word with no output produced.
REQ-026 When rst and in_valid are both high, reset SHALL win and nothing is captured.

Structure
REQ-027 Package xs3_pkg SHALL hold the state type (IDLE=2'b00, CONV=2'b01, DONE=2'b10), XS3_BIAS=4'd3 and BCD_MAX=4'd9.
REQ-028 The single-digit conversion SHALL be a combinational sub-module xs3_digit (4-bit in, 4-bit out, invalid flag), instantiated once.
REQ-029 Target implementation size SHALL be about 150-250 RTL lines, excluding package.

Verification
REQ-030 Bench SHALL cover, with NDIG=4: accept 0x9501 with out_ready=1 -> xs3_out=0xC834, err=0, out_valid high exactly 4 cycles after acceptance edge.
REQ-031 Bench SHALL cover: 0x0000 -> 0x3333, err=0; 0x9999 -> 0xCCCC, err=0.
REQ-032 Bench SHALL cover: 0x1A23 -> xs3_out=0x4D56, err=1; the next word 0x0001 -> 0x3334 with err=0 (error cleared per word).
REQ-033 Bench SHALL cover backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 -> outputs stable, in_ready=0, no second capture; out_ready=1 -> IDLE next cycle.
REQ-034 Bench SHALL cover reset during CONV at idx=2 -> next cycle state IDLE, out_valid=0, in_ready=1, xs3_out=0; a fresh word then converts correctly.
REQ-035 Bench SHALL cover back-to-back: in_valid held high continuously with out_ready=1 -> acceptances spaced exactly NDIG+2 cycles apart, results in order.
